// File: rtl/garage_pkg.sv
// Shared door-controller constants: state encodings and default timing.
// Imported by the actuator and by the garage system that instantiates it.
package garage_pkg;

    localparam logic [2:0] ST_CLOSED    = 3'd0;
    localparam logic [2:0] ST_OPENING   = 3'd1;
    localparam logic [2:0] ST_OPEN_HOLD = 3'd2;
    localparam logic [2:0] ST_CLOSING   = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    localparam int DEF_CNT_W          = 8;
    localparam int DEF_HOLD_CYCLES    = 20;
    localparam int DEF_TRAVEL_TIMEOUT = 50;

    // States in which the motor is driving and the travel watchdog applies.
    function automatic logic is_travel(input logic [2:0] state);
        return (state == ST_OPENING) || (state == ST_CLOSING);
    endfunction

endpackage

// File: rtl/door_timer.sv
// Clear/enable cycle counter that saturates at all-ones and flags equality with a compare value.
// One cycle from i_clr/i_en to the updated count; no backpressure.
module door_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cmp,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat,
    output logic             o_eq
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = &r_cnt;
    assign o_eq  = (r_cnt == i_cmp);

endmodule

// File: rtl/garage_door_actuator.sv
// Door actuator: turns a level open command into motor drive with hold, reversal and watchdog.
// Outputs decode the state register, so one cycle from input sample to response; no backpressure.
module garage_door_actuator
    import garage_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TRAVEL_TIMEOUT = DEF_TRAVEL_TIMEOUT
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Open_door,
    input  logic Door_open_limit,
    input  logic Door_closed_limit,
    input  logic Obstacle,
    input  logic Fault_clear,
    output logic Motor_up,
    output logic Motor_down,
    output logic Door_busy,
    output logic Door_fault,
    output logic Door_closed_pulse
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_closed_pulse;
    logic             w_clr;
    logic             w_en;
    logic [CNT_W-1:0] w_cmp;
    logic [CNT_W-1:0] w_cnt;
    logic             w_sat;
    logic             w_eq;
    logic             w_conflict;
    logic             w_timeout;
    logic             w_reverse;

    // One counter serves both the hold timer and the travel watchdog.
    assign w_cmp = (r_state == ST_OPEN_HOLD) ? HOLD_LAST : TRAVEL_LAST;

    door_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_cmp   (w_cmp),
        .o_cnt   (w_cnt),
        .o_sat   (w_sat),
        .o_eq    (w_eq)
    );

    assign w_conflict = Door_open_limit && Door_closed_limit;
    assign w_timeout  = is_travel(r_state) && w_eq;
    assign w_reverse  = Obstacle || Open_door;

    always_comb begin
        w_next = r_state;
        if (w_conflict) begin
            w_next = ST_FAULT;
        end else begin
            case (r_state)
                ST_CLOSED: begin
                    if (Open_door) w_next = ST_OPENING;
                end
                ST_OPENING: begin
                    if (w_timeout)            w_next = ST_FAULT;
                    else if (Door_open_limit) w_next = ST_OPEN_HOLD;
                end
                ST_OPEN_HOLD: begin
                    if (!Open_door && w_eq) w_next = ST_CLOSING;
                end
                ST_CLOSING: begin
                    if (w_timeout)              w_next = ST_FAULT;
                    else if (w_reverse)         w_next = ST_OPENING;
                    else if (Door_closed_limit) w_next = ST_CLOSED;
                end
                ST_FAULT: begin
                    if (Fault_clear) w_next = ST_CLOSING;
                end
                default: w_next = ST_FAULT;
            endcase
        end
    end

    // Every state entry starts the counter from zero; holding the door open pins it at zero.
    assign w_clr = (w_next != r_state)
                || (r_state == ST_CLOSED)
                || (r_state == ST_FAULT)
                || ((r_state == ST_OPEN_HOLD) && Open_door);
    assign w_en  = is_travel(r_state) || (r_state == ST_OPEN_HOLD);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= ST_CLOSED;
            r_closed_pulse <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_closed_pulse <= (r_state == ST_CLOSING) && (w_next == ST_CLOSED);
        end
    end

    assign Motor_up          = (r_state == ST_OPENING);
    assign Motor_down        = (r_state == ST_CLOSING);
    assign Door_busy         = (r_state != ST_CLOSED);
    assign Door_fault        = (r_state == ST_FAULT);
    assign Door_closed_pulse = r_closed_pulse;

endmodule

// File: tb/tb_garage_door_actuator.sv
// Directed bench for garage_door_actuator with HOLD_CYCLES=4, TRAVEL_TIMEOUT=8.
// Expected outputs packed as {Motor_up, Motor_down, Door_busy, Door_fault, Door_closed_pulse}.
module tb_garage_door_actuator;

    localparam logic [4:0] E_IDLE  = 5'b00000;
    localparam logic [4:0] E_UP    = 5'b10100;
    localparam logic [4:0] E_DOWN  = 5'b01100;
    localparam logic [4:0] E_HOLD  = 5'b00100;
    localparam logic [4:0] E_FAULT = 5'b00110;
    localparam logic [4:0] E_PULSE = 5'b00001;

    logic Clk;
    logic Reset_n;
    logic Open_door;
    logic Door_open_limit;
    logic Door_closed_limit;
    logic Obstacle;
    logic Fault_clear;
    logic Motor_up;
    logic Motor_down;
    logic Door_busy;
    logic Door_fault;
    logic Door_closed_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       open;
        logic       olim;
        logic       clim;
        logic       obs;
        logic       fclr;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[12];

    garage_door_actuator #(
        .CNT_W          (8),
        .HOLD_CYCLES    (4),
        .TRAVEL_TIMEOUT (8)
    ) dut (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .Open_door         (Open_door),
        .Door_open_limit   (Door_open_limit),
        .Door_closed_limit (Door_closed_limit),
        .Obstacle          (Obstacle),
        .Fault_clear       (Fault_clear),
        .Motor_up          (Motor_up),
        .Motor_down        (Motor_down),
        .Door_busy         (Door_busy),
        .Door_fault        (Door_fault),
        .Door_closed_pulse (Door_closed_pulse)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        checks++;
        if (Motor_up && Motor_down) begin
            errors++;
            $display("FAIL motor_exclusive at %0t: Motor_up=1 Motor_down=1, required not both", $time);
        end
    end

    function automatic vec_t mk(input logic o, input logic ol, input logic cl, input logic ob,
                                input logic fc, input logic [4:0] e, input string n);
        vec_t v;
        v.open = o; v.olim = ol; v.clim = cl; v.obs = ob; v.fclr = fc; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic drive(input logic o, input logic ol, input logic cl, input logic ob, input logic fc);
        Open_door         = o;
        Door_open_limit   = ol;
        Door_closed_limit = cl;
        Obstacle          = ob;
        Fault_clear       = fc;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = {Motor_up, Motor_down, Door_busy, Door_fault, Door_closed_pulse};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: up/down/busy/fault/pulse=%b required %b", name, $time, got, exp);
        end
    endtask

    initial begin
        // Normal open/hold/close cycle starting from CLOSED.
        tbl[0]  = mk(1, 0, 0, 0, 0, E_UP,    "norm_open_cmd");
        tbl[1]  = mk(0, 0, 0, 0, 0, E_UP,    "norm_opening1");
        tbl[2]  = mk(0, 0, 0, 0, 0, E_UP,    "norm_opening2");
        tbl[3]  = mk(0, 1, 0, 0, 0, E_HOLD,  "norm_open_limit");
        tbl[4]  = mk(0, 1, 0, 0, 0, E_HOLD,  "norm_hold1");
        tbl[5]  = mk(0, 1, 0, 0, 0, E_HOLD,  "norm_hold2");
        tbl[6]  = mk(0, 1, 0, 0, 0, E_HOLD,  "norm_hold3");
        tbl[7]  = mk(0, 1, 0, 0, 0, E_DOWN,  "norm_close_start");
        tbl[8]  = mk(0, 0, 0, 0, 0, E_DOWN,  "norm_closing1");
        tbl[9]  = mk(0, 0, 0, 0, 0, E_DOWN,  "norm_closing2");
        tbl[10] = mk(0, 0, 1, 0, 0, E_PULSE, "norm_closed_pulse");
        tbl[11] = mk(0, 0, 1, 0, 0, E_IDLE,  "norm_pulse_single");

        // Reset behaviour, including an open command held during reset.
        Reset_n = 1'b0;
        drive(1, 0, 0, 0, 0);
        #12;
        check("reset_outputs", E_IDLE);
        tick();
        check("reset_open_ignored", E_IDLE);
        drive(0, 0, 0, 0, 0);
        #9;
        Reset_n = 1'b1;
        tick();
        check("post_reset_idle", E_IDLE);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].open, tbl[i].olim, tbl[i].clim, tbl[i].obs, tbl[i].fclr);
            tick();
            check(tbl[i].name, tbl[i].exp);
        end

        // Hold extension: counter pinned while the command stays high.
        drive(1, 0, 1, 0, 0);
        tick();
        check("hx_opening", E_UP);
        drive(1, 1, 0, 0, 0);
        tick();
        check("hx_hold_enter", E_HOLD);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hx_held_open", E_HOLD);
        end
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hx_hold_countdown", E_HOLD);
        end
        tick();
        check("hx_close_after_4", E_DOWN);

        // Obstacle in the second closing cycle reverses the door.
        drive(0, 0, 0, 0, 0);
        tick();
        check("obs_closing2", E_DOWN);
        drive(0, 0, 0, 1, 0);
        tick();
        check("obs_reverse", E_UP);
        drive(0, 0, 0, 0, 0);
        tick();
        check("obs_reopening", E_UP);
        drive(0, 1, 0, 0, 0);
        tick();
        check("obs_back_to_hold", E_HOLD);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("obs_hold_countdown", E_HOLD);
        end
        tick();
        check("obs_close_again", E_DOWN);
        drive(0, 0, 1, 0, 0);
        tick();
        check("obs_closed_pulse", E_PULSE);

        // Travel watchdog: no open limit ever arrives.
        drive(1, 0, 1, 0, 0);
        tick();
        check("to_opening", E_UP);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_still_opening", E_UP);
        end
        tick();
        check("to_fault", E_FAULT);
        tick();
        check("to_fault_ignores_open", E_FAULT);
        drive(0, 0, 1, 0, 1);
        tick();
        check("to_fault_clear", E_DOWN);
        drive(0, 0, 1, 0, 0);
        tick();
        check("to_closed_after_clear", E_PULSE);

        // Sensor conflict while holding open.
        drive(1, 0, 1, 0, 0);
        tick();
        check("cf_opening", E_UP);
        drive(0, 1, 0, 0, 0);
        tick();
        check("cf_hold", E_HOLD);
        drive(0, 1, 1, 0, 0);
        tick();
        check("cf_fault", E_FAULT);
        drive(0, 1, 1, 0, 1);
        tick();
        check("cf_conflict_beats_clear", E_FAULT);
        drive(0, 0, 1, 0, 1);
        tick();
        check("cf_clear", E_DOWN);
        drive(0, 0, 1, 0, 0);
        tick();
        check("cf_closed", E_PULSE);

        // Reset mid-travel stops the motor without waiting for a clock edge.
        drive(1, 0, 1, 0, 0);
        tick();
        check("rst_mid_opening", E_UP);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_async_kill", E_IDLE);
        drive(0, 0, 1, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        check("rst_released_idle", E_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
